// File: rtl/pack_nx_byte_framed.sv
// Byte packer for the serial link transmit path: N_BYTES-wide words in, one byte per
// active slot clock out (LSB first), K-character framing, one-word pending buffer.
module pack_nx_byte_framed #(
  parameter int unsigned N_BYTES     = 11,
  parameter int unsigned SLOT_PERIOD = 10,
  parameter int unsigned SLOT_ACTIVE = 8,
  parameter logic [7:0]  IDLE_K      = 8'hBC,
  parameter bit          SOF_EN      = 1'b1,
  parameter logic [7:0]  SOF_K       = 8'hFB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [8*N_BYTES-1:0] data_in,
  output logic                 ready_out,
  output logic [7:0]           data_out,
  output logic                 k_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 overflow
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int SC_W  = $clog2(SLOT_PERIOD + 1);

  typedef logic [N_BYTES-1:0][7:0] word_t;
  typedef enum logic {IDLE, DATA} state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   slot_cnt_q, slot_cnt_d;
  word_t             cur_q, cur_d;
  word_t             pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              k_out_q, k_out_d;
  logic              valid_out_q, valid_out_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic active;
  logic accept;

  assign active    = (slot_cnt_q < SC_W'(SLOT_ACTIVE));
  assign ready_out = !pend_full_q && !rst;
  assign accept    = valid_in && ready_out;

  always_comb begin
    slot_cnt_d  = (slot_cnt_q == SC_W'(SLOT_PERIOD - 1)) ? '0 : slot_cnt_q + SC_W'(1);
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    k_out_d     = k_out_q;
    valid_out_d = active;
    overflow_d  = overflow_q | (valid_in & ~ready_out);

    // accept needs an empty pend slot, the move below needs a full one: never both
    if (accept) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
    end

    if (active) begin
      unique case (state_q)
        IDLE: begin
          if (!pend_full_q) begin
            data_out_d = IDLE_K;
            k_out_d    = 1'b1;
          end else begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
            if (SOF_EN) begin
              data_out_d = SOF_K;
              k_out_d    = 1'b1;
              idx_d      = '0;
              state_d    = DATA;
            end else begin
              // byte 0 goes straight out, so a single-byte word never enters DATA
              data_out_d = pend_q[0];
              k_out_d    = 1'b0;
              idx_d      = (N_BYTES == 1) ? '0 : IDX_W'(1);
              state_d    = (N_BYTES == 1) ? IDLE : DATA;
            end
          end
        end
        DATA: begin
          data_out_d = cur_q[idx_q];
          k_out_d    = 1'b0;
          if (idx_q == IDX_W'(N_BYTES - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == DATA) || pend_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_cnt_q  <= '0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      data_out_q  <= IDLE_K;
      k_out_q     <= 1'b1;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      k_out_q     <= k_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign k_out     = k_out_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule
